// File: rtl/pm_dc_shifter.sv
// Pixel-matrix digital-configuration shifter.
// Captures one per-pixel configuration word and streams it serially, MSB first,
// once for every pixel in the chain (far pixel first). Each bit gets a low and
// a high pm_sclk phase of HALF_PERIOD system cycles. A pm_latch strobe follows
// the last bit, then a one-cycle done pulse. Every output is a flop whose next
// value is derived from the next FSM state, so outputs track the state register.
module pm_dc_shifter #(
    parameter int PIXELS      = 4,
    parameter int CFG_BITS    = 8,
    parameter int HALF_PERIOD = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [CFG_BITS-1:0] cfg_word,
    output logic                pm_sclk,
    output logic                pm_sdata,
    output logic                pm_latch,
    output logic                busy,
    output logic                done
);

    localparam int N  = PIXELS * CFG_BITS;
    localparam int PW = $clog2(HALF_PERIOD) + 1;
    localparam int BW = $clog2(N) + 1;

    localparam logic [PW-1:0] PHASE_LAST = PW'(HALF_PERIOD - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(N - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHIFT_LO = 3'd1,
        SHIFT_HI = 3'd2,
        LATCH    = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       phase_q, phase_d;
    logic [BW-1:0]       bit_q,   bit_d;
    logic [CFG_BITS-1:0] shadow_q, shadow_d;

    logic sclk_q,  sclk_d;
    logic sdata_q, sdata_d;
    logic latch_q, latch_d;
    logic busy_q,  busy_d;
    logic done_q,  done_d;

    // Set when the next state is a fresh SHIFT_LO; only then may pm_sdata move.
    logic load_bit;
    logic next_bit;

    // Rotate left by one. The shadow is rotated as each bit is issued, so after
    // CFG_BITS bits it holds the original word again, ready for the next pixel.
    // Written with shifts so it also elaborates cleanly for CFG_BITS == 1.
    function automatic logic [CFG_BITS-1:0] rotl1(input logic [CFG_BITS-1:0] v);
        logic [CFG_BITS-1:0] r;
        r = (v << 1) | (v >> (CFG_BITS - 1));
        return r;
    endfunction

    // Next-state, counter and shadow-register logic.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        shadow_d = shadow_q;
        load_bit = 1'b0;
        next_bit = shadow_q[CFG_BITS-1];

        case (state_q)
            IDLE: begin
                // abort is ignored here; start always wins.
                phase_d = '0;
                bit_d   = '0;
                if (start) begin
                    // First bit comes straight from cfg_word; the shadow keeps
                    // the rotated copy so later cfg_word changes have no effect.
                    shadow_d = rotl1(cfg_word);
                    next_bit = cfg_word[CFG_BITS-1];
                    load_bit = 1'b1;
                    state_d  = SHIFT_LO;
                end
            end

            SHIFT_LO: begin
                if (abort) begin
                    state_d = IDLE;
                    phase_d = '0;
                    bit_d   = '0;
                end else if (phase_q == PHASE_LAST) begin
                    phase_d = '0;
                    state_d = SHIFT_HI;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end

            SHIFT_HI: begin
                if (abort) begin
                    state_d = IDLE;
                    phase_d = '0;
                    bit_d   = '0;
                end else if (phase_q == PHASE_LAST) begin
                    phase_d = '0;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
                        state_d = LATCH;
                    end else begin
                        shadow_d = rotl1(shadow_q);
                        next_bit = shadow_q[CFG_BITS-1];
                        load_bit = 1'b1;
                        state_d  = SHIFT_LO;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end

            LATCH: begin
                if (abort) begin
                    state_d = IDLE;
                    phase_d = '0;
                    bit_d   = '0;
                end else if (phase_q == PHASE_LAST) begin
                    phase_d = '0;
                    state_d = DONE;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end

            DONE: begin
                // start seen here is dropped; the FSM only listens in IDLE.
                state_d = IDLE;
                phase_d = '0;
                bit_d   = '0;
            end

            default: begin
                state_d = IDLE;
                phase_d = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Output decode from the next state, so every output is registered.
    always_comb begin
        sclk_d  = (state_d == SHIFT_HI);
        latch_d = (state_d == LATCH);
        busy_d  = (state_d == SHIFT_LO) || (state_d == SHIFT_HI) || (state_d == LATCH);
        done_d  = (state_d == DONE);
        if (load_bit) begin
            sdata_d = next_bit;
        end else if ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) begin
            sdata_d = sdata_q;
        end else begin
            sdata_d = 1'b0;
        end
    end

    // State, counter, shadow and output registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            bit_q    <= '0;
            shadow_q <= '0;
            sclk_q   <= 1'b0;
            sdata_q  <= 1'b0;
            latch_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            shadow_q <= shadow_d;
            sclk_q   <= sclk_d;
            sdata_q  <= sdata_d;
            latch_q  <= latch_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign pm_sclk  = sclk_q;
    assign pm_sdata = sdata_q;
    assign pm_latch = latch_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
